// File: rtl/arm_pkg.sv
// Shared types and constants for the ARMv4-subset processor system.
// Contents: opcode, command, condition and shift enums, the NZCV flag
// struct, datapath select codes, memory depth and a barrel-shift helper.
package arm_pkg;

  localparam int unsigned MEM_WORDS = 1048576;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    CMD_AND = 4'b0000,
    CMD_EOR = 4'b0001,
    CMD_SUB = 4'b0010,
    CMD_ADD = 4'b0100,
    CMD_CMP = 4'b1010,
    CMD_ORR = 4'b1100,
    CMD_MOV = 4'b1101
  } cmd_e;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Register-file write data and next-PC source selects.
  typedef enum logic [1:0] {WD_ALU = 2'd0, WD_MEM = 2'd1, WD_LINK = 2'd2} wd_sel_e;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_ALU = 2'd1, PC_MEM = 2'd2} pc_sel_e;

  // Shift by a literal amount; an amount of 0 leaves the value unchanged.
  function automatic logic [31:0] shift32(input logic [31:0] x, input logic [4:0] n,
                                          input shift_e t);
    logic [63:0] d;
    d = {x, x} >> n;
    case (t)
      SH_LSL:  return x << n;
      SH_LSR:  return x >> n;
      SH_ASR:  return 32'($signed(x) >>> n);
      default: return d[31:0];
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU with NZCV outputs.
// Ports: a, b (operands), cmd (command code), result, flags ({N,Z,C,V}).
module alu import arm_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  cmd,
  output logic [31:0] result,
  output logic [3:0]  flags
);
  logic        sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        ovf;

  // Subtraction is a + ~b + 1, so C is the ARM not-borrow.
  always_comb begin
    sub   = (cmd == CMD_SUB) || (cmd == CMD_CMP);
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + 33'(sub);
    ovf   = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    case (cmd_e'(cmd))
      CMD_AND: result = a & b;
      CMD_EOR: result = a ^ b;
      CMD_ORR: result = a | b;
      CMD_MOV: result = b;
      default: result = sum[31:0];
    endcase
    flags = {result[31], result == '0, sum[32], ovf};
  end
endmodule

// File: rtl/arm_cpu.sv
// Single-cycle CPU core: controller plus datapath.
// Ports: clk, reset, instr, read_data in; pc, alu_result, write_data,
// mem_write out.
module arm_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] read_data,
  output logic [31:0] pc,
  output logic [31:0] alu_result,
  output logic [31:0] write_data,
  output logic        mem_write
);
  logic [3:0] ra1, ra2, wa3, alu_cmd, alu_flags;
  logic       imm_sel, reg_write;
  logic [1:0] wd_sel, pc_sel;

  controller controller (
    .clk, .reset, .instr, .alu_flags, .ra1, .ra2, .wa3, .alu_cmd,
    .imm_sel, .reg_write, .mem_write, .wd_sel, .pc_sel
  );

  data_path data_path (
    .clk, .reset, .instr, .read_data, .ra1, .ra2, .wa3, .alu_cmd, .imm_sel,
    .reg_write, .wd_sel, .pc_sel, .imem_addr(pc), .alu_result, .write_data,
    .alu_flags
  );
endmodule

// File: rtl/controller.sv
// Decode, condition check and NZCV flag register.
// Ports: clk, reset, instr, alu_flags in; register addresses, ALU command,
// operand/write-data/next-PC selects and write enables out.
module controller import arm_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  ra1,
  output logic [3:0]  ra2,
  output logic [3:0]  wa3,
  output logic [3:0]  alu_cmd,
  output logic        imm_sel,
  output logic        reg_write,
  output logic        mem_write,
  output logic [1:0]  wd_sel,
  output logic [1:0]  pc_sel
);
  op_e   op;
  cmd_e  cmd;
  cond_e cond;
  nzcv_t flags, alu_f, next_flags;
  logic  cond_ok, set_flags, arith;
  logic [3:0] rd;
  logic  unused_bits;

  assign op    = op_e'(instr[27:26]);
  assign cmd   = cmd_e'(instr[24:21]);
  assign cond  = cond_e'(instr[31:28]);
  assign rd    = instr[15:12];
  assign alu_f = alu_flags;
  assign unused_bits = ^instr[11:4];

  // Condition evaluation against the committed flags.
  always_comb begin
    case (cond)
      COND_EQ: cond_ok = flags.z;
      COND_NE: cond_ok = !flags.z;
      COND_CS: cond_ok = flags.c;
      COND_CC: cond_ok = !flags.c;
      COND_MI: cond_ok = flags.n;
      COND_PL: cond_ok = !flags.n;
      COND_VS: cond_ok = flags.v;
      COND_VC: cond_ok = !flags.v;
      COND_HI: cond_ok = flags.c && !flags.z;
      COND_LS: cond_ok = !flags.c || flags.z;
      COND_GE: cond_ok = flags.n == flags.v;
      COND_LT: cond_ok = flags.n != flags.v;
      COND_GT: cond_ok = !flags.z && (flags.n == flags.v);
      COND_LE: cond_ok = flags.z || (flags.n != flags.v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Instruction decode; anything unrecognised falls through as a no-op.
  always_comb begin
    ra1       = instr[19:16];
    ra2       = instr[3:0];
    wa3       = rd;
    alu_cmd   = CMD_ADD;
    imm_sel   = instr[25];
    reg_write = 1'b0;
    mem_write = 1'b0;
    wd_sel    = WD_ALU;
    pc_sel    = PC_PLUS4;
    set_flags = 1'b0;
    case (op)
      OP_DP: begin
        alu_cmd = cmd;
        if (cond_ok && (cmd inside {CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD,
                                    CMD_CMP, CMD_ORR, CMD_MOV})) begin
          set_flags = instr[20] || (cmd == CMD_CMP);
          if (cmd != CMD_CMP) begin
            if (rd == 4'd15) pc_sel = PC_ALU;
            else reg_write = 1'b1;
          end
        end
      end
      OP_MEM: begin
        imm_sel = 1'b1;
        alu_cmd = instr[23] ? CMD_ADD : CMD_SUB;
        ra2     = rd;
        if (cond_ok && !instr[25]) begin
          if (instr[20]) begin
            wd_sel = WD_MEM;
            if (rd == 4'd15) pc_sel = PC_MEM;
            else reg_write = 1'b1;
          end else begin
            mem_write = 1'b1;
          end
        end
      end
      OP_BR: begin
        imm_sel = 1'b1;
        ra1     = 4'd15;
        if (cond_ok) begin
          pc_sel = PC_ALU;
          if (instr[24]) begin
            reg_write = 1'b1;
            wa3       = 4'd14;
            wd_sel    = WD_LINK;
          end
        end
      end
      default: ;
    endcase
    if (reset) begin
      reg_write = 1'b0;
      mem_write = 1'b0;
      set_flags = 1'b0;
    end
  end

  // Logical operations keep the previous C and V.
  always_comb begin
    arith        = cmd inside {CMD_ADD, CMD_SUB, CMD_CMP};
    next_flags.n = alu_f.n;
    next_flags.z = alu_f.z;
    next_flags.c = arith ? alu_f.c : flags.c;
    next_flags.v = arith ? alu_f.v : flags.v;
  end

  always_ff @(posedge clk) begin
    if (reset) flags <= '0;
    else if (set_flags) flags <= next_flags;
  end
endmodule

// File: rtl/data_path.sv
// PC, register file, operand shifter, extender and ALU.
// Ports: clk, reset, instr, read_data and controller selects in;
// imem_addr (PC), alu_result, write_data (Rd for stores), alu_flags out.
module data_path import arm_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] read_data,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic [3:0]  wa3,
  input  logic [3:0]  alu_cmd,
  input  logic        imm_sel,
  input  logic        reg_write,
  input  logic [1:0]  wd_sel,
  input  logic [1:0]  pc_sel,
  output logic [31:0] imem_addr,
  output logic [31:0] alu_result,
  output logic [31:0] write_data,
  output logic [3:0]  alu_flags
);
  logic [31:0] pc, pc_plus4, pc_plus8, pc_next;
  logic [31:0] rd1, rd2, ext_imm, shifted, src_b, wd3;

  assign pc_plus4  = pc + 32'd4;
  assign pc_plus8  = pc + 32'd8;
  assign imem_addr = pc;

  register_file register_file (
    .clk, .we3(reg_write), .ra1, .ra2, .wa3, .wd3, .r15(pc_plus8), .rd1, .rd2
  );

  extender extender (.instr, .ext_imm);

  assign shifted    = shift32(rd2, instr[11:7], shift_e'(instr[6:5]));
  assign src_b      = imm_sel ? ext_imm : shifted;
  assign write_data = rd2;

  alu alu (.a(rd1), .b(src_b), .cmd(alu_cmd), .result(alu_result), .flags(alu_flags));

  always_comb begin
    case (wd_sel)
      WD_MEM:  wd3 = read_data;
      WD_LINK: wd3 = pc_plus4;
      default: wd3 = alu_result;
    endcase
    case (pc_sel)
      PC_ALU:  pc_next = alu_result;
      PC_MEM:  pc_next = read_data;
      default: pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else pc <= pc_next;
  end
endmodule

// File: rtl/dmem.sv
// Data memory: combinational word read, full-word write on rising edge.
// Ports: clk, we (write enable), addr (byte address), wd (write data), rd.
module dmem import arm_pkg::*; (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  logic [31:0] ram [0:MEM_WORDS-1];
  logic unused_addr;

  assign rd = (addr[31:22] == '0) ? ram[addr[21:2]] : 'x;
  assign unused_addr = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (we && addr[31:22] == '0) ram[addr[21:2]] <= wd;
  end
endmodule

// File: rtl/extender.sv
// Immediate generation per instruction class.
// Ports: instr (current instruction), ext_imm (32-bit operand).
module extender import arm_pkg::*; (
  input  logic [31:0] instr,
  output logic [31:0] ext_imm
);
  logic unused_bits;
  assign unused_bits = ^{instr[31:28], instr[25:24]};

  always_comb begin
    case (instr[27:26])
      2'b00:   ext_imm = shift32({24'b0, instr[7:0]}, {instr[11:8], 1'b0}, SH_ROR);
      2'b01:   ext_imm = {20'b0, instr[11:0]};
      default: ext_imm = {{6{instr[23]}}, instr[23:0], 2'b00};
    endcase
  end
endmodule

// File: rtl/imem.sv
// Instruction memory, combinational word read.
// Ports: addr (byte address), rd (word; X when outside the memory).
module imem import arm_pkg::*; (
  input  logic [31:0] addr,
  output logic [31:0] rd
);
  logic [31:0] ram [0:MEM_WORDS-1];
  logic unused_addr;

  // Addresses past the array read as X so the end of program is visible.
  assign rd = (addr[31:22] == '0) ? ram[addr[21:2]] : 'x;
  assign unused_addr = ^addr[1:0];
endmodule

// File: rtl/register_file.sv
// R0-R14 with two combinational read ports and one edge-written port.
// Ports: clk, we3/wa3/wd3 (write), ra1/ra2 -> rd1/rd2 (read), r15 (PC+8).
module register_file (
  input  logic        clk,
  input  logic        we3,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic [3:0]  wa3,
  input  logic [31:0] wd3,
  input  logic [31:0] r15,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] reg_file [0:14];

  // R15 is the PC and lives in the datapath, never in this array.
  always_ff @(posedge clk) begin
    if (we3 && wa3 != 4'd15) reg_file[wa3] <= wd3;
  end

  assign rd1 = (ra1 == 4'd15) ? r15 : reg_file[ra1];
  assign rd2 = (ra2 == 4'd15) ? r15 : reg_file[ra2];
endmodule

// File: rtl/arm_system_top.sv
// Processor system: CPU core with instruction and data memories.
// Ports: clk, reset (sync, active-high); write_data, data_memory_addr and
// mem_write expose the data-memory write bus.
module arm_system_top (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] write_data,
  output logic [31:0] data_memory_addr,
  output logic        mem_write
);
  logic [31:0] pc, instr, read_data;

  arm_cpu arm_cpu (
    .clk, .reset, .instr, .read_data, .pc, .alu_result(data_memory_addr),
    .write_data, .mem_write
  );

  imem imem (.addr(pc), .rd(instr));

  dmem dmem (.clk, .we(mem_write), .addr(data_memory_addr), .wd(write_data), .rd(read_data));
endmodule

// File: tb/tb_arm_system_top.sv
// Directed bench for arm_system_top: short hand-assembled programs with
// hand-computed register, flag, PC and store-bus expectations.
module tb_arm_system_top;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] write_data, data_memory_addr;
  logic        mem_write;
  int          total = 0;
  int          bad = 0;

  arm_system_top dut (.clk, .reset, .write_data, .data_memory_addr, .mem_write);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int unsigned a, input logic [31:0] w);
    dut.imem.ram[a >> 2] = w;
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.arm_cpu.data_path.register_file.reg_file[i];
  endfunction

  function automatic logic [31:0] pc();
    return dut.arm_cpu.data_path.pc;
  endfunction

  function automatic logic [31:0] nzcv();
    return {28'b0, dut.arm_cpu.controller.flags};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    check("reset_pc", pc(), 32'h0);
    reset = 1'b0;
    dut.arm_cpu.data_path.register_file.reg_file[13] = 32'h003FFFFC;
    dut.arm_cpu.data_path.register_file.reg_file[14] = 32'h00400000;
  endtask

  initial begin
    // Reset with a store at address 0: bus shows it, write suppressed.
    dut.arm_cpu.data_path.register_file.reg_file[13] = 32'h003FFFFC;
    put(32'h00, 32'hE50D2004);
    step(1);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    check("rst_addr", data_memory_addr, 32'h003FFFF8);
    check("rst_pc", pc(), 32'h0);

    // MOV/MOV/ADD/STR, then LDR back.
    put(32'h00, 32'hE3A00005);
    put(32'h04, 32'hE3A01007);
    put(32'h08, 32'hE0802001);
    put(32'h0C, 32'hE50D2004);
    put(32'h10, 32'hE51D5004);
    put(32'h14, 32'hEAFFFFFE);
    do_reset();
    step(3);
    check("add_r2", rf(2), 32'd12);
    check("str_mem_write", {31'b0, mem_write}, 32'h1);
    check("str_addr", data_memory_addr, 32'h003FFFF8);
    check("str_data", write_data, 32'd12);
    step(1);
    check("str_ram", dut.dmem.ram[20'hFFFFE], 32'd12);
    step(1);
    check("ldr_r5", rf(5), 32'd12);
    check("idle_mem_write", {31'b0, mem_write}, 32'h0);

    // SUBS sets Z and C; ADDNE skipped, ADDEQ taken.
    put(32'h00, 32'hE3A00005);
    put(32'h04, 32'hE3A04003);
    put(32'h08, 32'hE0503000);
    put(32'h0C, 32'h12844001);
    put(32'h10, 32'h02844001);
    put(32'h14, 32'hEAFFFFFE);
    do_reset();
    step(3);
    check("subs_r3", rf(3), 32'h0);
    check("subs_flags", nzcv(), 32'h6);
    step(1);
    check("addne_r4", rf(4), 32'd3);
    step(1);
    check("addeq_r4", rf(4), 32'd4);

    // Rotated immediate, then CMP (no register write).
    put(32'h00, 32'hE3A004FF);
    put(32'h04, 32'hE3500001);
    put(32'h08, 32'hEAFFFFFE);
    do_reset();
    step(1);
    check("rot_imm_r0", rf(0), 32'hFF000000);
    step(1);
    check("cmp_flags", nzcv(), 32'hA);
    check("cmp_no_write", rf(0), 32'hFF000000);

    // BL forward two instructions, then MOV PC,LR.
    put(32'h00, 32'hE3A00001);
    put(32'h04, 32'hE3A01002);
    put(32'h08, 32'hE3A02003);
    put(32'h0C, 32'hE3A03004);
    put(32'h10, 32'hEB000002);
    put(32'h14, 32'hEAFFFFFE);
    put(32'h18, 32'hE3A05055);
    put(32'h1C, 32'hE3A05055);
    put(32'h20, 32'hE3A06066);
    put(32'h24, 32'hE1A0F00E);
    do_reset();
    check("reset_flags", nzcv(), 32'h0);
    dut.arm_cpu.data_path.register_file.reg_file[5] = 32'h0;
    step(5);
    check("bl_pc", pc(), 32'h20);
    check("bl_lr", rf(14), 32'h14);
    step(1);
    check("bl_target_r6", rf(6), 32'h66);
    step(1);
    check("ret_pc", pc(), 32'h14);
    check("bl_skipped_r5", rf(5), 32'h0);
    step(2);
    check("spin_pc", pc(), 32'h14);

    // Countdown loop with SUBS/BNE, result stored after exit.
    put(32'h00, 32'hE3A0000A);
    put(32'h04, 32'hE3A01000);
    put(32'h08, 32'hE2811001);
    put(32'h0C, 32'hE2500001);
    put(32'h10, 32'h1AFFFFFC);
    put(32'h14, 32'hE50D1008);
    put(32'h18, 32'hEAFFFFFE);
    do_reset();
    step(5);
    check("loop1_pc", pc(), 32'h08);
    check("loop1_r0", rf(0), 32'd9);
    step(27);
    check("loop_exit_pc", pc(), 32'h14);
    check("loop_r0", rf(0), 32'd0);
    check("loop_count", rf(1), 32'd10);
    check("loop_str_addr", data_memory_addr, 32'h003FFFF4);
    check("loop_str_data", write_data, 32'd10);
    step(1);
    check("loop_ram", dut.dmem.ram[20'hFFFFD], 32'd10);

    // Return to LR=0x00400000 leaves instruction memory.
    put(32'h00, 32'hE3A07001);
    put(32'h04, 32'hE1A0F00E);
    do_reset();
    step(2);
    check("end_r7", rf(7), 32'd1);
    check("end_pc", pc(), 32'h00400000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
